uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmitter. Serializes a parallel byte into an asynchronous frame:
//  start, DBIT data bits LSB-first, optional parity, stop.
//  Bit timing comes from the shared oversampling baud tick generator (s_tick, SAMPLE ticks per bit).
//  Sits between the TX FIFO read side and the tx pad.
// PARAMETERS
//  DBIT    8   data bits per frame (5..9)
//  SAMPLE  16  s_tick pulses per bit period
//  SB_TICK 16  s_tick pulses in stop period (16=1, 24=1.5, 32=2 stop bits)
//  PARITY  0   0=none, 1=odd, 2=even
// PORTS
//  clk           in   1     system clock
//  reset_n       in   1     async active-low reset
//  s_tick        in   1     oversampling tick, 1-clk pulse
//  tx_start      in   1     request to send din (1-clk pulse or level)
//  din           in   DBIT  byte to transmit
//  tx_busy       out  1     frame in progress (state != IDLE)
//  tx_done_tick  out  1     1-clk pulse at end of stop period
//  tx            out  1     serial line, idle high, registered
// BEHAVIOUR
//  Reset: reset_n is asynchronous, active-low; clock is clk.
//   - On reset: tx=1, tx_busy=0, tx_done_tick=0, state=IDLE, all counters=0, shift reg=0.
//   - Reset mid-frame aborts the frame; tx returns high immediately, no done pulse.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   - IDLE: tx=1. tx_start=1 -> latch din into b_reg, s_cnt=0, go START. Start is not gated by s_tick.
//   - START: tx=0. Count s_tick; at s_cnt==SAMPLE-1 on a tick -> s_cnt=0, n_cnt=0, go DATA.
//   - DATA: tx=b_reg[0]. At s_cnt==SAMPLE-1 on a tick -> shift b_reg right.
//     If n_cnt==DBIT-1 -> PARITY (PARITY!=0) or STOP; else n_cnt+1.
//   - PARITY: tx = ^din_latched (even) or ~^din_latched (odd). Lasts SAMPLE ticks, then STOP.
//   - STOP: tx=1. At s_cnt==SB_TICK-1 on a tick -> tx_done_tick=1 for that clk, go IDLE.
//  Timing:
//   - tx is registered: it changes on the clk edge after the state change.
//   - First start-bit low appears 1 clk after tx_start is accepted.
//   - Each bit lasts exactly SAMPLE s_ticks (stop lasts SB_TICK).
//  Handshake:
//   - tx_start while busy (any non-IDLE state, including the done cycle) is ignored, not queued.
//   - din is sampled only on acceptance; later changes of din do not affect the frame.
//   - Back-to-back: tx_start held high re-accepts on the first IDLE cycle.
//     Minimum inter-frame gap is 1 clk of idle-high beyond the stop period.
//  Widths and counter rules:
//   - s_cnt is $clog2(max(SAMPLE,SB_TICK)) bits; n_cnt is $clog2(DBIT) bits.
//   - Counters advance only when s_tick=1 and never wrap past their terminal count.
//   - s_tick held high continuously is legal: 1 bit = SAMPLE clks.
// STRUCTURE
//  - uart_pkg: state encoding localparams, PARITY_NONE/ODD/EVEN constants, shared by rx and tx.
//  - Single module, no sub-modules. Tick generator and FIFO are instantiated at the uart top level.
// TESTING (SAMPLE=16, SB_TICK=16, DBIT=8, s_tick every 4 clk)
//  1. Reset asserted mid-DATA -> tx=1 and tx_busy=0 asynchronously; no tx_done_tick.
//  2. PARITY=0, din=8'hA5, tx_start pulse -> tx = 0,1,0,1,0,0,1,0,1,1, each held 64 clk.
//     tx_done_tick is one pulse; tx_busy is high for 640 clk.
//  3. PARITY=2, din=8'hA5 -> parity bit 0. PARITY=1, din=8'hA5 -> parity bit 1.
//     Frame length is 11 bits.
//  4. tx_start pulsed again mid-frame with din=8'h3C -> ignored; line carries only 8'hA5 and one done pulse.
//  5. tx_start held high, din=8'h00 then 8'hFF -> two frames.
//     Exactly 1 idle clk between stop end and the next start bit.
//  6. s_tick tied high -> each bit 16 clk. SB_TICK=32 -> stop bit 32 clk.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver and transmitter:
//   - uart_state_e : frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - PARITY_*     : values accepted by the PARITY parameter
//   - max_int      : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Larger of two integers, used to size the shared oversample counter.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmitter. Serialises a parallel word into an asynchronous frame:
//   start bit, DBIT data bits LSB first, optional parity bit, stop period.
//   Bit timing is driven by an external oversampling tick (SAMPLE ticks per
//   bit, SB_TICK ticks for the stop period).
//
// Parameters
//   DBIT    data bits per frame (5..9)
//   SAMPLE  s_tick pulses per bit period
//   SB_TICK s_tick pulses in the stop period (16/24/32 = 1/1.5/2 stop bits)
//   PARITY  PARITY_NONE / PARITY_ODD / PARITY_EVEN
//
// Ports
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   s_tick_i        oversampling tick, one clk wide
//   tx_start_i      request to send din_i (pulse or level)
//   din_i           word to transmit, sampled only when the request is accepted
//   tx_busy_o       frame in progress (state is not IDLE)
//   tx_done_tick_o  one-clk pulse on the final tick of the stop period
//   tx_o            serial line, idle high, registered
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SAMPLE  = 16,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick_i,
    input  logic            tx_start_i,
    input  logic [DBIT-1:0] din_i,
    output logic            tx_busy_o,
    output logic            tx_done_tick_o,
    output logic            tx_o
);

    // One counter serves both data bits and the stop period, so it must hold
    // the larger terminal count.
    localparam int SW = $clog2(max_int(SAMPLE, SB_TICK));
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(SAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] b_q,     b_d;
    logic            par_q,   par_d;
    logic            tx_q,    tx_d;
    logic            done_s;

    // Parity bit of the word as captured at acceptance. Odd parity makes the
    // total count of ones odd, even parity makes it even.
    function automatic logic calc_parity(input logic [DBIT-1:0] d);
        if (PARITY == PARITY_ODD) begin
            return ~^d;
        end else begin
            return ^d;
        end
    endfunction

    // State register: FSM state, counters, shift register and line driver.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: counters only move on s_tick and reset to zero at
    // their terminal count instead of wrapping.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                // Acceptance is not tick-aligned; the start bit simply runs
                // SAMPLE ticks from here.
                if (tx_start_i) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                    n_cnt_d = '0;
                    b_d     = din_i;
                    par_d   = calc_parity(din_i);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (s_tick_i) begin
                    if (s_cnt_q == S_BIT_LAST) begin
                        state_d = ST_DATA;
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end else begin
                    s_cnt_d = s_cnt_q;
                end
            end
            ST_DATA: begin
                if (s_tick_i) begin
                    if (s_cnt_q == S_BIT_LAST) begin
                        s_cnt_d = '0;
                        b_d     = {1'b0, b_q[DBIT-1:1]};
                        if (n_cnt_q == N_LAST) begin
                            n_cnt_d = '0;
                            if (PARITY != PARITY_NONE) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d = ST_STOP;
                            end
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end else begin
                    s_cnt_d = s_cnt_q;
                end
            end
            ST_PARITY: begin
                if (s_tick_i) begin
                    if (s_cnt_q == S_BIT_LAST) begin
                        state_d = ST_STOP;
                        s_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end else begin
                    s_cnt_d = s_cnt_q;
                end
            end
            ST_STOP: begin
                if (s_tick_i) begin
                    if (s_cnt_q == S_STOP_LAST) begin
                        state_d = ST_IDLE;
                        s_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end else begin
                    s_cnt_d = s_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_cnt_d = '0;
                n_cnt_d = '0;
            end
        endcase
    end

    // Output decode: tx_d is the level of the current state, so the line
    // follows the state one clk later. The done pulse is raised while still
    // in STOP, which keeps that cycle busy so a held tx_start waits for IDLE.
    always_comb begin
        tx_d   = 1'b1;
        done_s = 1'b0;
        case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = b_q[0];
            ST_PARITY: tx_d = par_q;
            ST_STOP: begin
                tx_d = 1'b1;
                if (s_tick_i && (s_cnt_q == S_STOP_LAST)) begin
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx_o           = tx_q;
    assign tx_busy_o      = (state_q != ST_IDLE);
    assign tx_done_tick_o = done_s;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Four transmitters (no parity, even, odd, no parity with 2 stop bits) share
//   one stimulus stream. A tick-count frame model predicts tx, busy and done
//   every cycle; hand-computed literals pin the model down.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_tick;
    logic         tx_start;
    logic [7:0]   din;
    logic [N-1:0] tx_w;
    logic [N-1:0] busy_w;
    logic [N-1:0] done_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit tick_always = 1'b0;
    int dcnt [N];
    int bcnt [N];
    int lcnt [N];
    int d0   [N];
    int b0   [N];
    int l0   [N];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DBIT(8), .SAMPLE(16), .SB_TICK(16), .PARITY(0)) dut_none (
        .clk(clk), .reset_n(reset_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .din_i(din),
        .tx_busy_o(busy_w[0]), .tx_done_tick_o(done_w[0]), .tx_o(tx_w[0]));
    uart_tx_serializer #(.DBIT(8), .SAMPLE(16), .SB_TICK(16), .PARITY(2)) dut_even (
        .clk(clk), .reset_n(reset_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .din_i(din),
        .tx_busy_o(busy_w[1]), .tx_done_tick_o(done_w[1]), .tx_o(tx_w[1]));
    uart_tx_serializer #(.DBIT(8), .SAMPLE(16), .SB_TICK(16), .PARITY(1)) dut_odd (
        .clk(clk), .reset_n(reset_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .din_i(din),
        .tx_busy_o(busy_w[2]), .tx_done_tick_o(done_w[2]), .tx_o(tx_w[2]));
    uart_tx_serializer #(.DBIT(8), .SAMPLE(16), .SB_TICK(32), .PARITY(0)) dut_sb32 (
        .clk(clk), .reset_n(reset_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .din_i(din),
        .tx_busy_o(busy_w[3]), .tx_done_tick_o(done_w[3]), .tx_o(tx_w[3]));

    // ---------------- frame model: levels indexed by ticks since acceptance
    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sb_of(input int i);
        return (i == 3) ? 32 : 16;
    endfunction

    function automatic int nbits(input int i);
        return (par_of(i) != 0) ? 11 : 10;
    endfunction

    // Tick count at which bit b of the frame ends.
    function automatic int bit_end(input int i, input int b);
        if (b < nbits(i) - 1) return 16 * (b + 1);
        return 16 * (nbits(i) - 1) + sb_of(i);
    endfunction

    function automatic int frame_len(input int i);
        return bit_end(i, nbits(i) - 1);
    endfunction

    function automatic int seg(input int i, input int t);
        for (int b = 0; b < nbits(i); b++) begin
            if (t < bit_end(i, b)) return b;
        end
        return nbits(i) - 1;
    endfunction

    function automatic logic [11:0] build(input int i, input logic [7:0] d);
        logic [11:0] l;
        int ones;
        l    = '1;
        l[0] = 1'b0;
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            l[k+1] = d[k];
            ones   = ones + int'(d[k]);
        end
        if (par_of(i) == 2) l[9] = (ones % 2 == 1);
        else if (par_of(i) == 1) l[9] = (ones % 2 == 0);
        return l;
    endfunction

    logic        m_active    [N];
    int          m_ticks     [N];
    logic [11:0] m_lvl       [N];
    logic        m_state_lvl [N];
    logic        m_tx        [N];

    // Model update: line shows the frame level of the previous cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_active[i]    <= 1'b0;
                m_ticks[i]     <= 0;
                m_lvl[i]       <= '1;
                m_state_lvl[i] <= 1'b1;
                m_tx[i]        <= 1'b1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                m_tx[i] <= m_state_lvl[i];
                if (m_active[i]) begin
                    m_ticks[i] <= m_ticks[i] + (s_tick ? 1 : 0);
                    if (m_ticks[i] + (s_tick ? 1 : 0) >= frame_len(i)) begin
                        m_active[i]    <= 1'b0;
                        m_state_lvl[i] <= 1'b1;
                    end else begin
                        m_state_lvl[i] <= m_lvl[i][seg(i, m_ticks[i] + (s_tick ? 1 : 0))];
                    end
                end else if (tx_start) begin
                    m_active[i]    <= 1'b1;
                    m_ticks[i]     <= 0;
                    m_lvl[i]       <= build(i, din);
                    m_state_lvl[i] <= 1'b0;
                end else begin
                    m_state_lvl[i] <= 1'b1;
                end
            end
        end
    end

    // ---------------- checking helpers
    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d expected=%0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    // One clock: compare against the model at negedge, then drive the tick.
    task automatic step();
        @(negedge clk);
        if (reset_n) begin
            for (int i = 0; i < N; i++) begin
                chk("tx", i, int'(tx_w[i]), int'(m_tx[i]));
                chk("busy", i, int'(busy_w[i]), int'(m_active[i]));
                chk("done", i, int'(done_w[i]),
                    int'(m_active[i] && s_tick && (m_ticks[i] + 1 == frame_len(i))));
                dcnt[i] += int'(done_w[i]);
                bcnt[i] += int'(busy_w[i]);
                lcnt[i] += int'(!tx_w[i]);
            end
        end
        @(posedge clk);
        #2;
        cyc++;
        s_tick = tick_always || (cyc % 4 == 0);
    endtask

    task automatic snap();
        for (int i = 0; i < N; i++) begin
            d0[i] = dcnt[i];
            b0[i] = bcnt[i];
            l0[i] = lcnt[i];
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000 && busy_w != '0; k++) step();
        chk("idle_timeout", 0, int'(busy_w), 0);
        step();
    endtask

    // Raise tx_start for one clk in a cycle that also carries a tick.
    task automatic pulse_aligned(input logic [7:0] d);
        do step(); while (!s_tick);
        din      = d;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
    endtask

    logic [10:0] samp [N];
    int run, first_run;
    bit seen_low;

    initial begin
        for (int i = 0; i < N; i++) begin
            dcnt[i] = 0;
            bcnt[i] = 0;
            lcnt[i] = 0;
        end
        reset_n  = 1'b1;
        s_tick   = 1'b0;
        tx_start = 1'b0;
        din      = 8'h00;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_tx", 0, int'(tx_w), 15);
        chk("reset_busy", 0, int'(busy_w), 0);
        chk("reset_done", 0, int'(done_w), 0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();

        // A5 frame, with a rejected 3C request in the middle of data bit 3.
        snap();
        pulse_aligned(8'hA5);
        repeat (33) step();
        for (int b = 0; b < 11; b++) begin
            for (int i = 0; i < N; i++) samp[i][b] = tx_w[i];
            if (b == 4) begin
                din      = 8'h3C;
                tx_start = 1'b1;
                step();
                tx_start = 1'b0;
                repeat (63) step();
            end else begin
                repeat (64) step();
            end
        end
        wait_idle();
        chk("a5_bits_none", 0, int'(samp[0]), int'(11'b11101001010));
        chk("a5_bits_even", 1, int'(samp[1]), int'(11'b10101001010));
        chk("a5_bits_odd", 2, int'(samp[2]), int'(11'b11101001010));
        chk("a5_bits_sb32", 3, int'(samp[3]), int'(11'b11101001010));
        chk("a5_busy_clks", 0, bcnt[0] - b0[0], 640);
        chk("a5_busy_clks", 1, bcnt[1] - b0[1], 704);
        chk("a5_busy_clks", 3, bcnt[3] - b0[3], 704);
        for (int i = 0; i < N; i++) chk("a5_done_pulses", i, dcnt[i] - d0[i], 1);

        // Back-to-back: tx_start held, 00 then FF.
        snap();
        run       = 0;
        first_run = -1;
        seen_low  = 1'b0;
        din       = 8'h00;
        tx_start  = 1'b1;
        step();
        din = 8'hFF;
        for (int k = 0; k < 720; k++) begin
            step();
            if (tx_w[0]) begin
                if (seen_low) run++;
            end else begin
                if (seen_low && run > 0 && first_run < 0) first_run = run;
                run      = 0;
                seen_low = 1'b1;
            end
        end
        tx_start = 1'b0;
        wait_idle();
        chk("b2b_stop_plus_gap", 0, first_run, 65);
        for (int i = 0; i < N; i++) chk("b2b_done_pulses", i, dcnt[i] - d0[i], 2);

        // s_tick tied high: one bit per 16 clk, 2 stop bits = 32 clk.
        tick_always = 1'b1;
        step();
        snap();
        din      = 8'hFF;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        wait_idle();
        chk("fast_busy_clks", 0, bcnt[0] - b0[0], 160);
        chk("fast_busy_clks", 1, bcnt[1] - b0[1], 176);
        chk("fast_busy_clks", 3, bcnt[3] - b0[3], 176);
        chk("fast_low_clks", 0, lcnt[0] - l0[0], 16);
        chk("fast_low_clks", 1, lcnt[1] - l0[1], 32);
        chk("fast_low_clks", 2, lcnt[2] - l0[2], 16);
        chk("fast_low_clks", 3, lcnt[3] - l0[3], 16);
        tick_always = 1'b0;

        // Reset in the middle of the data bits aborts the frame at once.
        snap();
        pulse_aligned(8'hA5);
        repeat (200) step();
        chk("pre_reset_busy", 0, int'(busy_w), 15);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_tx", 0, int'(tx_w), 15);
        chk("abort_busy", 0, int'(busy_w), 0);
        chk("abort_done", 0, int'(done_w), 0);
        #20 reset_n = 1'b1;
        repeat (5) step();
        chk("abort_no_done", 0, dcnt[0] - d0[0], 0);
        chk("abort_idle_tx", 0, int'(tx_w), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
